// File: rtl/avg_round_pipe.sv
// Shift-and-round stage for RVV averaging add/sub and scaling shifts; per-element, SEW-selectable.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle throughput.
// Backpressure: stalls when out_valid & !out_ready, holding up to 2 beats with stable outputs.
module avg_round_pipe #(
    parameter int DATA_WIDTH    = 64,
    parameter int DW_B          = DATA_WIDTH / 8,
    parameter int SEW_WIDTH     = 2,
    parameter bit ENABLE_64_BIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [DW_B-1:0]       in_carry,
    input  logic                  in_signed,
    input  logic [SEW_WIDTH-1:0]  in_sew,
    input  logic [5:0]            in_shamt,
    input  logic [1:0]            in_vxrm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_vec
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_sh;
    logic [DW_B-1:0]       s1_r;
    logic [SEW_WIDTH-1:0]  s1_sew;
    logic                  adv2;
    logic                  adv1;

    // Per-SEW candidate results; the sew code picks one lane-wide view.
    logic [3:0][DATA_WIDTH-1:0] sh_all;
    logic [3:0][DW_B-1:0]       r_all;
    logic [3:0][DATA_WIDTH-1:0] sum_all;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int W   = 8 << g;
        localparam int NE  = DATA_WIDTH / W;
        localparam int LW  = $clog2(W);
        localparam int BPE = W / 8;

        if ((g == 3 && !ENABLE_64_BIT) || NE == 0) begin : g_off
            assign sh_all[g]  = '0;
            assign r_all[g]   = '0;
            assign sum_all[g] = '0;
        end else begin : g_on
            for (genvar e = 0; e < NE; e++) begin : g_elem
                localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};
                logic           c;
                logic [2*W-1:0] v;
                logic [2*W-1:0] lo_mask;
                logic [W-1:0]   sh;
                logic [LW-1:0]  d;
                logic           guard;
                logic           sticky;
                logic           any;
                logic           r;

                assign c       = in_carry[e*BPE + BPE - 1];
                assign v       = {{(W-1){in_signed & c}}, c, in_vec[e*W +: W]};
                assign d       = in_shamt[LW-1:0];
                assign sh      = W'(v >> d);
                // lo_mask covers the d bits shifted out; empty when d=0 so no mode rounds.
                assign lo_mask = (ONE << d) - ONE;
                assign guard   = |(v & (lo_mask ^ (lo_mask >> 1)));
                assign sticky  = |(v & (lo_mask >> 1));
                assign any     = |(v & lo_mask);

                always_comb begin
                    r = 1'b0;
                    case (in_vxrm)
                        2'd0:    r = guard;
                        2'd1:    r = guard & (sticky | sh[0]);
                        2'd2:    r = 1'b0;
                        default: r = !sh[0] & any;
                    endcase
                end

                assign sh_all[g][e*W +: W] = sh;
                assign r_all[g][e*BPE]     = r;
                if (BPE > 1) begin : g_rpad
                    assign r_all[g][e*BPE+1 +: BPE-1] = '0;
                end
                assign sum_all[g][e*W +: W] = s1_sh[e*W +: W] + {{(W-1){1'b0}}, s1_r[e*BPE]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sh     <= '0;
            s1_r      <= '0;
            s1_sew    <= '0;
            out_valid <= 1'b0;
            out_vec   <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sh  <= sh_all[in_sew];
                    s1_r   <= r_all[in_sew];
                    s1_sew <= in_sew;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_vec <= sum_all[s1_sew];
                end
            end
        end
    end

endmodule

// File: tb/tb_avg_round_pipe.sv
// Directed bench for avg_round_pipe: rounding modes, carry fill, element isolation, handshake, reset.
module tb_avg_round_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_vec;
    logic [7:0]  in_carry;
    logic        in_signed;
    logic [1:0]  in_sew;
    logic [5:0]  in_shamt;
    logic [1:0]  in_vxrm;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vec;
    logic        n64_in_ready;
    logic        n64_out_valid;
    logic [63:0] n64_out_vec;

    int checks   = 0;
    int failures = 0;

    avg_round_pipe #(.DATA_WIDTH(64), .ENABLE_64_BIT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_carry(in_carry), .in_signed(in_signed), .in_sew(in_sew),
        .in_shamt(in_shamt), .in_vxrm(in_vxrm), .out_valid(out_valid),
        .out_ready(out_ready), .out_vec(out_vec)
    );

    avg_round_pipe #(.DATA_WIDTH(64), .ENABLE_64_BIT(1'b0)) dut_n64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n64_in_ready),
        .in_vec(in_vec), .in_carry(in_carry), .in_signed(in_signed), .in_sew(in_sew),
        .in_shamt(in_shamt), .in_vxrm(in_vxrm), .out_valid(n64_out_valid),
        .out_ready(out_ready), .out_vec(n64_out_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [63:0] vec, input logic [7:0] carry, input logic sgn,
                          input logic [1:0] sew, input logic [5:0] shamt, input logic [1:0] vxrm);
        in_vec    = vec;
        in_carry  = carry;
        in_signed = sgn;
        in_sew    = sew;
        in_shamt  = shamt;
        in_vxrm   = vxrm;
    endtask

    // One beat through an empty pipeline with out_ready high; checks exact 2-cycle latency.
    task automatic beat(input string tag, input logic [63:0] vec, input logic [7:0] carry,
                        input logic sgn, input logic [1:0] sew, input logic [5:0] shamt,
                        input logic [1:0] vxrm, input logic [63:0] exp);
        @(posedge clk); #1;
        set_in(vec, carry, sgn, sew, shamt, vxrm);
        in_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk); #2;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk(tag, out_vec, exp);
    endtask

    initial begin
        logic [63:0] d32;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_in(64'd0, 8'd0, 1'b0, 2'd0, 6'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_vec", out_vec, 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // SEW=8 unsigned shamt=1: elements 0x07, 0x05, 0xFE with carry on element 2.
        beat("s8_rnu", 64'h0000_0000_00FE_0507, 8'h04, 1'b0, 2'd0, 6'd1, 2'd0, 64'h0000_0000_00FF_0304);
        beat("s8_rne", 64'h0000_0000_00FE_0507, 8'h04, 1'b0, 2'd0, 6'd1, 2'd1, 64'h0000_0000_00FF_0204);
        beat("s8_rdn", 64'h0000_0000_00FE_0507, 8'h04, 1'b0, 2'd0, 6'd1, 2'd2, 64'h0000_0000_00FF_0203);
        beat("s8_rod", 64'h0000_0000_00FE_0507, 8'h04, 1'b0, 2'd0, 6'd1, 2'd3, 64'h0000_0000_00FF_0303);

        // SEW=8 signed: 0xFD with carry (-3) and 0x07 without.
        beat("s8_sgn_rnu", 64'h0000_0000_0000_07FD, 8'h01, 1'b1, 2'd0, 6'd1, 2'd0, 64'h0000_0000_0000_04FF);
        beat("s8_sgn_rdn", 64'h0000_0000_0000_07FD, 8'h01, 1'b1, 2'd0, 6'd1, 2'd2, 64'h0000_0000_0000_03FE);
        beat("s8_sgn_rne", 64'h0000_0000_0000_07FD, 8'h01, 1'b1, 2'd0, 6'd1, 2'd1, 64'h0000_0000_0000_04FE);

        // SEW=16 signed shamt=4; carry bits 0 and 2 are not top bytes and must be ignored.
        beat("s16_rnu", 64'h0000_0000_0018_8001, 8'h07, 1'b1, 2'd1, 6'd4, 2'd0, 64'h0000_0000_0002_F800);
        beat("s16_rod", 64'h0000_0000_0018_8001, 8'h07, 1'b1, 2'd1, 6'd4, 2'd3, 64'h0000_0000_0001_F801);
        beat("s16_sh20_rne", 64'h0000_0000_0018_8001, 8'h07, 1'b1, 2'd1, 6'd20, 2'd1, 64'h0000_0000_0002_F800);
        beat("s16_sh20_rnu", 64'h0000_0000_0018_8001, 8'h07, 1'b1, 2'd1, 6'd20, 2'd0, 64'h0000_0000_0002_F800);

        // SEW=32 shamt=0: elements pass through unchanged in every mode.
        d32 = 64'h7FFF_FFFF_0000_0003;
        for (int m = 0; m < 4; m++) begin
            beat($sformatf("s32_sh0_m%0d", m), d32, 8'h00, 1'b1, 2'd2, 6'd0, 2'(m), d32);
        end

        // SEW=64: built instance rounds, the instance without 64-bit support returns zero.
        beat("s64_rnu", 64'h0000_0000_0000_0007, 8'h00, 1'b0, 2'd3, 6'd1, 2'd0, 64'h0000_0000_0000_0004);
        chk("n64_valid", 64'(n64_out_valid), 64'd1);
        chk("n64_vec", n64_out_vec, 64'd0);

        // Backpressure: four SEW=8 pass-through beats with out_ready low.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(64'h11, 8'h00, 1'b0, 2'd0, 6'd0, 2'd2);
        in_valid = 1'b1;
        #1 chk("bp_rdy1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_vec = 64'h22;
        #1 chk("bp_rdy2", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_vec = 64'h33;
        #1;
        chk("bp_rdy3_blocked", 64'(in_ready), 64'd0);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_vec", out_vec, 64'h11);
        @(posedge clk); #2;
        chk("bp_still_blocked", 64'(in_ready), 64'd0);
        chk("bp_stable_vec", out_vec, 64'h11);
        out_ready = 1'b1;
        #1 chk("bp_rdy_released", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_vec = 64'h44;
        #1;
        chk("bp_drain2_valid", 64'(out_valid), 64'd1);
        chk("bp_drain2", out_vec, 64'h22);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk("bp_drain3", out_vec, 64'h33);
        @(posedge clk); #2;
        chk("bp_drain4", out_vec, 64'h44);
        @(posedge clk); #2;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Reset with two beats held: neither may emerge.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(64'hAA, 8'h00, 1'b0, 2'd0, 6'd0, 2'd2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_vec = 64'hBB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk("rst_pre_vec", out_vec, 64'hAA);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_vec", out_vec, 64'd0);
        chk("rst_mid_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            chk($sformatf("rst_no_emerge_%0d", k), 64'(out_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
